// File: rtl/vga_ctrl_pkg.sv
// Shared types and helpers for the VGA color sequencing path.
package vga_ctrl_pkg;

   localparam int unsigned COLOR_W = 3;
   localparam int unsigned SW_W    = 8;

   typedef enum logic [1:0] {
      AUTO,
      HOLD,
      PEND
   } state_t;

   // Index of the highest set bit; callers treat an all-zero input separately.
   function automatic logic [COLOR_W-1:0] hi_idx(input logic [SW_W-1:0] v);
      logic [COLOR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < SW_W; i++) begin
         if (v[i]) idx = COLOR_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus per-vector debounce for the board switches.
module switch_debounce #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_sw,
   output logic [WIDTH-1:0] o_db_val
);

   localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_s2_q;
   logic [CNT_W-1:0] r_cnt;

   // r_s2_q lets a fresh change in s2 restart the stability count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1     <= '0;
         r_s2     <= '0;
         r_s2_q   <= '0;
         r_cnt    <= '0;
         o_db_val <= '0;
      end else begin
         r_s1   <= i_sw;
         r_s2   <= r_s1;
         r_s2_q <= r_s2;
         if (r_s2 == o_db_val) begin
            r_cnt <= '0;
         end else if (r_s2 != r_s2_q) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
            o_db_val <= r_s2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/vga_color_ctrl.sv
// Color select sequencer: debounced switches or auto-cycle, committed only at frame start.
module vga_color_ctrl
   import vga_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES   = 16,
   parameter int unsigned AUTO_FRAMES = 60
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SW_W-1:0]    switch,
   input  logic               frame_start,
   output logic [COLOR_W-1:0] rgb_sel,
   output logic               changed,
   output logic               auto_mode
);

   localparam int unsigned FCNT_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

   logic [SW_W-1:0]    w_db_val;
   logic [COLOR_W-1:0] w_code;
   state_t             r_state;
   logic [FCNT_W-1:0]  r_fcnt;

   switch_debounce #(
      .WIDTH     (SW_W),
      .DB_CYCLES (DB_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .i_sw     (switch),
      .o_db_val (w_db_val)
   );

   assign w_code = hi_idx(w_db_val);

   // auto_mode is written alongside every state change so it tracks r_state exactly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= AUTO;
         r_fcnt    <= '0;
         rgb_sel   <= '0;
         changed   <= 1'b0;
         auto_mode <= 1'b1;
      end else begin
         changed <= 1'b0;
         case (r_state)
            AUTO: begin
               if (w_db_val != '0) begin
                  r_state   <= PEND;
                  auto_mode <= 1'b0;
               end else if (frame_start) begin
                  if (r_fcnt == FCNT_W'(AUTO_FRAMES - 1)) begin
                     rgb_sel <= rgb_sel + COLOR_W'(1);
                     r_fcnt  <= '0;
                     changed <= 1'b1;
                  end else begin
                     r_fcnt <= r_fcnt + FCNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (w_db_val == '0) begin
                  r_state   <= AUTO;
                  r_fcnt    <= '0;
                  auto_mode <= 1'b1;
               end else if (w_code != rgb_sel) begin
                  r_state <= PEND;
               end
            end
            PEND: begin
               if (w_db_val == '0) begin
                  r_state   <= AUTO;
                  r_fcnt    <= '0;
                  auto_mode <= 1'b1;
               end else if (w_code == rgb_sel) begin
                  r_state <= HOLD;
               end else if (frame_start) begin
                  rgb_sel <= w_code;
                  r_state <= HOLD;
                  changed <= 1'b1;
               end
            end
            default: begin
               r_state   <= AUTO;
               auto_mode <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_color_ctrl.sv
// Scoreboard bench for vga_color_ctrl: each changed pulse pops the expected committed color.
module tb_vga_color_ctrl;

   localparam int unsigned DB = 4;
   localparam int unsigned AF = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] sw = '0;
   logic       fs = 1'b0;
   logic [2:0] rgb_sel;
   logic       changed;
   logic       auto_mode;

   int         n_checks  = 0;
   int         n_pass    = 0;
   int         n_changed = 0;
   logic [2:0] exp_q[$];

   vga_color_ctrl #(
      .DB_CYCLES   (DB),
      .AUTO_FRAMES (AF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .switch      (sw),
      .frame_start (fs),
      .rgb_sel     (rgb_sel),
      .changed     (changed),
      .auto_mode   (auto_mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame(input int n);
      fs = 1'b1;
      tick(n);
      fs = 1'b0;
      tick(1);
   endtask

   // Any changed pulse must match a color queued by the stimulus.
   always @(negedge clk) begin
      if (changed !== 1'b0) begin
         n_changed++;
         if (exp_q.size() == 0) chk("unexpected_changed", 32'(changed), 32'd0);
         else chk("commit_rgb_sel", 32'(rgb_sel), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #2 reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sw = 8'($urandom);
         fs = ~fs;
         tick(1);
      end
      fs = 1'b0;
      sw = '0;
      chk("reset_rgb_sel", 32'(rgb_sel), 32'd0);
      chk("reset_auto_mode", 32'(auto_mode), 32'd1);
      chk("reset_changed", 32'(changed), 32'd0);
      tick(1);
      reset = 1'b1;
      tick(4);

      // Auto-cycle: third frame steps, then 21 back-to-back frames wrap to 0.
      exp_q.push_back(3'd1);
      frame(1); frame(1);
      chk("auto_no_step_yet", 32'(rgb_sel), 32'd0);
      frame(1);
      chk("auto_step1", 32'(rgb_sel), 32'd1);
      chk("auto_one_pulse", 32'(n_changed), 32'd1);
      for (int c = 2; c <= 8; c++) exp_q.push_back(3'(c));
      frame(21);
      chk("auto_wrap", 32'(rgb_sel), 32'd0);
      chk("auto_pulses", 32'(n_changed), 32'd8);

      // Manual commit; the extra frame leaves fcnt nonzero for the return-to-auto test.
      frame(1);
      sw = 8'h08;
      tick(6);
      chk("db_not_yet", 32'(dut.u_debounce.o_db_val), 32'h00);
      tick(1);
      chk("db_latency", 32'(dut.u_debounce.o_db_val), 32'h08);
      tick(1);
      chk("pend_auto_mode", 32'(auto_mode), 32'd0);
      chk("pend_rgb_old", 32'(rgb_sel), 32'd0);
      exp_q.push_back(3'd3);
      frame(1);
      chk("manual_commit", 32'(rgb_sel), 32'd3);
      chk("manual_auto_mode", 32'(auto_mode), 32'd0);

      // Glitch rejection.
      sw = 8'h80;
      tick(3);
      sw = 8'h08;
      tick(8);
      chk("glitch_db", 32'(dut.u_debounce.o_db_val), 32'h08);
      frame(1); frame(1);
      chk("glitch_rgb", 32'(rgb_sel), 32'd3);

      // Priority and last-wins.
      sw = 8'h05;
      tick(10);
      chk("pend_no_commit", 32'(rgb_sel), 32'd3);
      sw = 8'h41;
      tick(10);
      exp_q.push_back(3'd6);
      frame(1);
      chk("last_wins", 32'(rgb_sel), 32'd6);
      sw = 8'h48;
      tick(10);
      frame(1);
      chk("same_code_hold", 32'(rgb_sel), 32'd6);

      // Return to auto with fcnt cleared.
      sw = 8'h00;
      tick(10);
      chk("back_auto_mode", 32'(auto_mode), 32'd1);
      frame(1); frame(1);
      chk("fcnt_cleared", 32'(rgb_sel), 32'd6);
      exp_q.push_back(3'd7);
      frame(1);
      chk("auto_after_manual", 32'(rgb_sel), 32'd7);

      // Coincident db_val update and frame_start defers the commit.
      sw = 8'h02;
      tick(10);
      exp_q.push_back(3'd1);
      frame(1);
      chk("commit_code1", 32'(rgb_sel), 32'd1);
      sw = 8'h08;
      tick(6);
      fs = 1'b1;
      tick(1);
      fs = 1'b0;
      chk("coincident_db", 32'(dut.u_debounce.o_db_val), 32'h08);
      tick(3);
      chk("coincident_deferred", 32'(rgb_sel), 32'd1);
      exp_q.push_back(3'd3);
      frame(1);
      chk("deferred_commit", 32'(rgb_sel), 32'd3);

      // Reset while pending code 5.
      sw = 8'h20;
      tick(10);
      chk("pend5_rgb_old", 32'(rgb_sel), 32'd3);
      chk("pend5_auto_mode", 32'(auto_mode), 32'd0);
      reset = 1'b0;
      fs = 1'b1;
      tick(2);
      chk("midpend_rgb", 32'(rgb_sel), 32'd0);
      chk("midpend_auto", 32'(auto_mode), 32'd1);
      chk("midpend_changed", 32'(changed), 32'd0);
      fs = 1'b0;
      sw = 8'h00;
      tick(1);
      reset = 1'b1;
      tick(4);
      chk("post_reset_rgb", 32'(rgb_sel), 32'd0);
      chk("post_reset_auto", 32'(auto_mode), 32'd1);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
